// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: default sizes,
// a constant-evaluable ceil-log2 helper and the status bundle used by monitors.
package fifo_pkg;

    localparam int FIFO_DEF_W     = 8;
    localparam int FIFO_DEF_DEPTH = 16;

    // Flag bundle; the top keeps its registered flags in this form so that
    // monitors can tap one vector.
    typedef struct packed {
        logic empty;
        logic full;
        logic aempty;
        logic afull;
        logic ovf;
        logic udf;
    } fifo_status_t;

    // Smallest r with 2**r >= value; usable in parameter and port expressions.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DATA_W x DEPTH dual-port storage: one synchronous write port and one read
// port. The read port is registered (latency 1, resets to zero) by default and
// becomes a combinational look-up of the addressed entry when FIFO_FWFT_EN is
// defined. Storage itself is never cleared.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DEF_W,
    parameter int DEPTH  = FIFO_DEF_DEPTH,
    parameter int AW     = clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented continuously; reset and read strobe are not needed.
    logic unused_s;
    assign unused_s = rst ^ rd_en;
    assign rd_data  = mem_r[rd_addr];
`else
    logic [DATA_W-1:0] rd_data_r;

    // Registered read: captures the addressed entry on an accepted read and
    // holds it until the next one. Reads the pre-write value on address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// levels and single-cycle overflow/underflow pulses. Pointer, occupancy and
// flag logic live here; storage is in fifo_dpram.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output
// (head entry always on buf_out, rd_en acts as pop acknowledge).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DEF_W,
    parameter int DEPTH  = FIFO_DEF_DEPTH,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      buf_in,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      buf_out,
    output logic                   buf_empty,
    output logic                   buf_full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   underflow,
    output logic [clog2(DEPTH):0]  fifo_counter
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_LVL);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_LVL);

    localparam fifo_status_t STATUS_RST = '{
        empty: 1'b1, full: 1'b0, aempty: 1'b1, afull: 1'b0, ovf: 1'b0, udf: 1'b0
    };

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          wr_ok_s;
    logic          rd_ok_s;
    fifo_status_t  status_r;
    fifo_status_t  status_next_s;

    // Accept decisions; a write at full is allowed only alongside an accepted read.
    always_comb begin
        rd_ok_s = rd_en & ~status_r.empty;
        wr_ok_s = wr_en & (~status_r.full | rd_ok_s);
    end

    // Next occupancy: simultaneous accepted read and write cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Flags derived from the next occupancy so they line up with fifo_counter.
    always_comb begin
        status_next_s        = STATUS_RST;
        status_next_s.empty  = (count_next_s == CNT_ZERO);
        status_next_s.full   = (count_next_s == CNT_DEPTH);
        status_next_s.aempty = (count_next_s <= CNT_AE);
        status_next_s.afull  = (count_next_s >= CNT_AF);
        status_next_s.ovf    = wr_en & ~wr_ok_s;
        status_next_s.udf    = rd_en & ~rd_ok_s;
    end

    // Pointer, occupancy and flag registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            status_r <= STATUS_RST;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r  <= count_next_s;
            status_r <= status_next_s;
        end
    end

    fifo_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (buf_in),
        .rd_en   (rd_ok_s),
        .rd_addr (rd_ptr_r),
        .rd_data (buf_out)
    );

    assign buf_empty    = status_r.empty;
    assign buf_full     = status_r.full;
    assign almost_empty = status_r.aempty;
    assign almost_full  = status_r.afull;
    assign overflow     = status_r.ovf;
    assign underflow    = status_r.udf;
    assign fifo_counter = count_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=12, AE=4).
// Works for both the registered-read and the FIFO_FWFT_EN build.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic       almost_empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
    logic [4:0] fifo_counter;

    int n_checks;
    int n_fail;

    sync_fifo_param #(
        .DATA_W (8),
        .DEPTH  (16),
        .AF_LVL (12),
        .AE_LVL (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow),
        .fifo_counter (fifo_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (fifo_counter !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_counter); end
        n_checks++;
        if ({buf_empty, buf_full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 101000",
                {buf_empty, buf_full, almost_empty, almost_full, overflow, underflow});
        end
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %0h expected 0", buf_out); end
`endif
        rst = 1'b0;
        // Partial burst, then an asynchronous reset pulse between edges.
        wr_en = 1'b1;
        buf_in = 8'h11; step();
        buf_in = 8'h22; step();
        buf_in = 8'h33; step();
        wr_en = 1'b0; rd_en = 1'b1; step();
        rd_en = 1'b0;
        n_checks++;
        if (fifo_counter !== 5'd2) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 2", fifo_counter); end
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h11) begin n_fail++; $display("FAIL pre_reset_out: got %0h expected 11", buf_out); end
`endif
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (fifo_counter !== 5'd0 || buf_empty !== 1'b1 || almost_empty !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: count %0d empty %b aempty %b, expected 0 1 1",
                fifo_counter, buf_empty, almost_empty);
        end
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h00) begin n_fail++; $display("FAIL async_reset_out: got %0h expected 0", buf_out); end
`endif
        #4 rst = 1'b0;
        step();
        n_checks++;
        if (fifo_counter !== 5'd0 || buf_empty !== 1'b1) begin
            n_fail++; $display("FAIL post_reset: count %0d empty %b, expected 0 1", fifo_counter, buf_empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; buf_in = 8'(i);
            step();
            n_checks++;
            if (fifo_counter !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, fifo_counter, i); end
            n_checks++;
            if ({buf_full, almost_full, buf_empty} !== {(i == 16), (i >= 12), 1'b0}) begin
                n_fail++; $display("FAIL fill_flags[%0d]: got %b expected %b", i,
                    {buf_full, almost_full, buf_empty}, {(i == 16), (i >= 12), 1'b0});
            end
        end
        buf_in = 8'hEE; step();
        wr_en = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || fifo_counter !== 5'd16) begin
            n_fail++; $display("FAIL overflow: ovf %b count %0d, expected 1 16", overflow, fifo_counter);
        end
        step();
        n_checks++;
        if (overflow !== 1'b0 || fifo_counter !== 5'd16) begin
            n_fail++; $display("FAIL overflow_pulse: ovf %b count %0d, expected 0 16", overflow, fifo_counter);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, buf_out, i); end
`endif
            step();
`ifndef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, buf_out, i); end
`endif
            n_checks++;
            if (fifo_counter !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, fifo_counter, 16 - i); end
            n_checks++;
            if ({buf_empty, almost_empty, almost_full} !== {(i == 16), ((16 - i) <= 4), ((16 - i) >= 12)}) begin
                n_fail++; $display("FAIL drain_flags[%0d]: got %b expected %b", i,
                    {buf_empty, almost_empty, almost_full}, {(i == 16), ((16 - i) <= 4), ((16 - i) >= 12)});
            end
        end
        step();
        rd_en = 1'b0;
        n_checks++;
        if (underflow !== 1'b1 || fifo_counter !== 5'd0) begin
            n_fail++; $display("FAIL underflow: udf %b count %0d, expected 1 0", underflow, fifo_counter);
        end
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h10) begin n_fail++; $display("FAIL underflow_hold: got %0h expected 10", buf_out); end
`endif
        step();
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got %b expected 0", underflow); end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_v;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            buf_in = 8'h20 + 8'(i); step();
        end
        rd_en = 1'b1; buf_in = 8'hAA; step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (fifo_counter !== 5'd16 || buf_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_rw: count %0d full %b ovf %b, expected 16 1 0", fifo_counter, buf_full, overflow);
        end
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h20) begin n_fail++; $display("FAIL full_rw_out: got %0h expected 20", buf_out); end
`endif
        for (int i = 0; i < 16; i++) begin
            exp_v = (i < 15) ? (8'h21 + 8'(i)) : 8'hAA;
            rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== exp_v) begin n_fail++; $display("FAIL full_rw_seq[%0d]: got %0h expected %0h", i, buf_out, exp_v); end
`endif
            step();
`ifndef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== exp_v) begin n_fail++; $display("FAIL full_rw_seq[%0d]: got %0h expected %0h", i, buf_out, exp_v); end
`endif
        end
        rd_en = 1'b0;
        n_checks++;
        if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL full_rw_empty: got %b expected 1", buf_empty); end
    endtask

    task automatic test_empty_rw();
        wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'h55; step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (underflow !== 1'b1 || fifo_counter !== 5'd1 || buf_empty !== 1'b0) begin
            n_fail++; $display("FAIL empty_rw: udf %b count %0d empty %b, expected 1 1 0", underflow, fifo_counter, buf_empty);
        end
        rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h55) begin n_fail++; $display("FAIL empty_rw_data: got %0h expected 55", buf_out); end
`endif
        step();
        rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (buf_out !== 8'h55) begin n_fail++; $display("FAIL empty_rw_data: got %0h expected 55", buf_out); end
`endif
        n_checks++;
        if (fifo_counter !== 5'd0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL empty_rw_after: count %0d udf %b, expected 0 0", fifo_counter, underflow);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp_out;
        logic       rd_ok;
        logic       wr_ok;
        exp_out = 8'h55;
        for (int c = 0; c < 40; c++) begin
            wr_en  = ((c % 5) != 4);
            rd_en  = ($urandom_range(0, 3) != 0);
            buf_in = 8'($urandom_range(0, 255));
            rd_ok  = rd_en && (q.size() != 0);
            wr_ok  = wr_en && ((q.size() < 16) || rd_ok);
`ifdef FIFO_FWFT_EN
            if (q.size() != 0) begin
                n_checks++;
                if (buf_out !== q[0]) begin n_fail++; $display("FAIL rand_head[%0d]: got %0h expected %0h", c, buf_out, q[0]); end
            end
`endif
            step();
            if (rd_ok) exp_out = q.pop_front();
            if (wr_ok) q.push_back(buf_in);
`ifndef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== exp_out) begin n_fail++; $display("FAIL rand_data[%0d]: got %0h expected %0h", c, buf_out, exp_out); end
`endif
            n_checks++;
            if (fifo_counter !== 5'(q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, fifo_counter, q.size()); end
            n_checks++;
            if ({overflow, underflow} !== {(wr_en && !wr_ok), (rd_en && !rd_ok)}) begin
                n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", c,
                    {overflow, underflow}, {(wr_en && !wr_ok), (rd_en && !rd_ok)});
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
`ifdef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== q[0]) begin n_fail++; $display("FAIL rand_drain[%0d]: got %0h expected %0h", c, buf_out, q[0]); end
`endif
            step();
            exp_out = q.pop_front();
`ifndef FIFO_FWFT_EN
            n_checks++;
            if (buf_out !== exp_out) begin n_fail++; $display("FAIL rand_drain[%0d]: got %0h expected %0h", c, buf_out, exp_out); end
`endif
        end
        rd_en = 1'b0;
        n_checks++;
        if (buf_empty !== 1'b1 || fifo_counter !== 5'd0) begin
            n_fail++; $display("FAIL rand_empty: empty %b count %0d, expected 1 0", buf_empty, fifo_counter);
        end
        // Single write into empty FIFO with no read request.
        wr_en = 1'b1; buf_in = 8'h33; step();
        wr_en = 1'b0;
        n_checks++;
        if (fifo_counter !== 5'd1) begin n_fail++; $display("FAIL write33_count: got %0d expected 1", fifo_counter); end
        n_checks++;
`ifdef FIFO_FWFT_EN
        if (buf_out !== 8'h33) begin n_fail++; $display("FAIL fwft_33: got %0h expected 33", buf_out); end
`else
        if (buf_out !== exp_out) begin n_fail++; $display("FAIL hold_no_read: got %0h expected %0h", buf_out, exp_out); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
